// File: rtl/mioc_pkg.sv
// Shared definitions for the memory/IO controller: bus widths, FSM
// state encodings, request kinds and the request-priority helper.
package mioc_pkg;

   localparam int                RegBus          = 32;
   localparam logic [RegBus-1:0] ZeroWord        = 32'h0000_0000;
   localparam logic [31:0]       MIOC_IO_BASE    = 32'hFFFF_F000;
   localparam int                MIOC_TO_DEFAULT = 255;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RAM_ACC = 3'd1,
      ST_RAM_CAP = 3'd2,
      ST_IO_WAIT = 3'd3,
      ST_DONE    = 3'd4
   } mioc_state_t;

   typedef enum logic [1:0] {
      K_RAM_RD = 2'd0,
      K_RAM_WR = 2'd1,
      K_IO_RD  = 2'd2,
      K_IO_WR  = 2'd3
   } mioc_kind_t;

   // Resolves simultaneous strobes: io_r > io_w > mr > mw.
   function automatic mioc_kind_t mioc_pick(input logic io_r, input logic io_w,
                                            input logic mr);
      mioc_kind_t k;
      if (io_r) begin
         k = K_IO_RD;
      end else if (io_w) begin
         k = K_IO_WR;
      end else if (mr) begin
         k = K_RAM_RD;
      end else begin
         k = K_RAM_WR;
      end
      return k;
   endfunction

   function automatic logic mioc_is_io(input mioc_kind_t k);
      return (k == K_IO_RD) || (k == K_IO_WR);
   endfunction

endpackage

// File: rtl/mioc_io_timer.sv
// IO wait-cycle counter. expired is high during the TIMEOUT-th
// consecutive enabled cycle, i.e. the last cycle an ack is still accepted.
module mioc_io_timer
   import mioc_pkg::*;
#(
   parameter int TIMEOUT = MIOC_TO_DEFAULT,
   parameter int TO_W    = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   logic [TO_W-1:0] cnt;

   // Count enabled cycles; cleared whenever the controller leaves IO_WAIT.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= {TO_W{1'b0}};
      end else if (en) begin
         cnt <= cnt + {{(TO_W-1){1'b0}}, 1'b1};
      end
   end

   assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/mioc_ctrl.sv
// Memory/IO controller: routes writeback-stage requests to the data RAM
// or the IO bus, stalls the pipeline while the access is in flight and
// returns load data on rm_idata.
module mioc_ctrl
   import mioc_pkg::*;
#(
   parameter int RAM_AW  = 10,
   parameter int TIMEOUT = MIOC_TO_DEFAULT,
   parameter int TO_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mr,
   input  logic              mw,
   input  logic              io_r,
   input  logic              io_w,
   input  logic [31:0]       m_iaddr,
   input  logic [31:0]       wm_idata,
   output logic [31:0]       rm_idata,
   output logic              stall_o,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata,
   output logic              io_req,
   output logic              io_we,
   output logic [31:0]       io_addr,
   output logic [31:0]       io_wdata,
   input  logic [31:0]       io_rdata,
   input  logic              io_ack,
   output logic              io_err
);

   mioc_state_t state, next_state;
   mioc_kind_t  kind, pick;
   logic [31:0] addr_q, wdata_q, rdata_q;
   logic        err_q, any_req, in_wait, expired;

   assign any_req = mr | mw | io_r | io_w;
   assign pick    = mioc_pick(io_r, io_w, mr);
   assign in_wait = (state == ST_IO_WAIT);

   mioc_io_timer #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clr     (!in_wait),
      .en      (in_wait),
      .expired (expired)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (any_req) begin
               next_state = mioc_is_io(pick) ? ST_IO_WAIT : ST_RAM_ACC;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_RAM_ACC: next_state = (kind == K_RAM_RD) ? ST_RAM_CAP : ST_DONE;
         ST_RAM_CAP: next_state = ST_DONE;
         ST_IO_WAIT: begin
            if (io_ack || expired) begin
               next_state = ST_DONE;
            end else begin
               next_state = ST_IO_WAIT;
            end
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   // Latch the accepted request (kind, address, store data) in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         kind    <= K_RAM_RD;
         addr_q  <= ZeroWord;
         wdata_q <= ZeroWord;
      end else if ((state == ST_IDLE) && any_req) begin
         kind    <= pick;
         addr_q  <= m_iaddr;
         wdata_q <= wm_idata;
      end
   end

   // Load-data capture and sticky timeout flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= ZeroWord;
         err_q   <= 1'b0;
      end else begin
         case (state)
            ST_RAM_CAP: rdata_q <= ram_rdata;
            ST_IO_WAIT: begin
               if (io_ack) begin
                  if (kind == K_IO_RD) rdata_q <= io_rdata;
               end else if (expired) begin
                  if (kind == K_IO_RD) rdata_q <= ZeroWord;
                  err_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output decode; the RAM strobes are also gated by rst so that a reset
   // during RAM_ACC never commits a write.
   always_comb begin
      stall_o   = 1'b0;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      ram_addr  = {RAM_AW{1'b0}};
      ram_wdata = ZeroWord;
      io_req    = 1'b0;
      io_we     = 1'b0;
      io_addr   = ZeroWord;
      io_wdata  = ZeroWord;
      case (state)
         ST_IDLE:    stall_o = any_req & ~rst;
         ST_RAM_ACC: begin
            stall_o  = ~rst;
            ram_en   = ~rst;
            ram_we   = ~rst & (kind == K_RAM_WR);
            ram_addr = addr_q[RAM_AW+1:2];
            if (kind == K_RAM_WR) begin
               ram_wdata = wdata_q;
            end else begin
               ram_wdata = ZeroWord;
            end
         end
         ST_RAM_CAP: stall_o = ~rst;
         ST_IO_WAIT: begin
            stall_o = ~rst;
            io_req  = 1'b1;
            io_we   = (kind == K_IO_WR);
            io_addr = addr_q;
            if (kind == K_IO_WR) begin
               io_wdata = wdata_q;
            end else begin
               io_wdata = ZeroWord;
            end
         end
         default: stall_o = 1'b0;
      endcase
   end

   assign rm_idata = rdata_q;
   assign io_err   = err_q;

endmodule

// File: tb/tb_mioc_ctrl.sv
// Scoreboard bench for mioc_ctrl: stimulus pushes the hand-computed
// expected outcome of each access; a monitor observes the stall window
// and compares when the access completes (stall_o falls).
module tb_mioc_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mr = 1'b0, mw = 1'b0, io_r = 1'b0, io_w = 1'b0;
   logic [31:0] m_iaddr = 32'h0, wm_idata = 32'h0;
   logic [31:0] rm_idata, ram_wdata, ram_rdata, io_addr, io_wdata, io_rdata;
   logic        stall_o, ram_en, ram_we, io_req, io_we, io_ack, io_err;
   logic [9:0]  ram_addr;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rm;
      int          stall;
      logic        err;
      int          nreq;
      int          nen;
      int          nwe;
      logic        iowe;
      logic [31:0] addr;
   } exp_t;

   exp_t sb[$];

   mioc_ctrl dut (
      .clk(clk), .rst(rst), .mr(mr), .mw(mw), .io_r(io_r), .io_w(io_w),
      .m_iaddr(m_iaddr), .wm_idata(wm_idata), .rm_idata(rm_idata),
      .stall_o(stall_o), .ram_en(ram_en), .ram_we(ram_we),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
      .io_err(io_err)
   );

   always #5 clk = ~clk;

   // Synchronous RAM model.
   logic [31:0] mem [0:1023] = '{default: 32'h0};
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata     <= mem[ram_addr];
      end
   end

   // IO device model: acks in the ack_delay-th io_req cycle (0 = never).
   int          ack_delay = 0;
   logic [31:0] dev_rdata = 32'h0;
   initial begin
      int n;
      n = 0;
      io_ack = 1'b0;
      io_rdata = 32'hBEEF_0000;
      forever begin
         @(negedge clk);
         if (io_req) n++;
         else        n = 0;
         io_ack   = io_req && (ack_delay != 0) && (n == ack_delay);
         io_rdata = io_ack ? dev_rdata : 32'hBEEF_0000;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: accumulates the stall window, compares on completion.
   initial begin
      int st, nreq, nen, nwe;
      logic iowe;
      logic [31:0] addr;
      exp_t e;
      st = 0; nreq = 0; nen = 0; nwe = 0; iowe = 1'b0; addr = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            st = 0; nreq = 0; nen = 0; nwe = 0; iowe = 1'b0; addr = 32'h0;
         end else if (stall_o) begin
            st++;
            if (io_req) begin nreq++; iowe = io_we; addr = io_addr; end
            if (ram_en) begin nen++; addr = {22'h0, ram_addr}; end
            if (ram_we) nwe++;
         end else if (st > 0) begin
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_empty: completion seen with no expected entry");
            end else begin
               e = sb.pop_front();
               chk("rm_idata", rm_idata, e.rm);
               chk("stall_cycles", 32'(st), 32'(e.stall));
               chk("io_err", {31'h0, io_err}, {31'h0, e.err});
               chk("io_req_cycles", 32'(nreq), 32'(e.nreq));
               chk("ram_en_cycles", 32'(nen), 32'(e.nen));
               chk("ram_we_cycles", 32'(nwe), 32'(e.nwe));
               chk("io_we", {31'h0, iowe}, {31'h0, e.iowe});
               chk("addr", addr, e.addr);
            end
            st = 0; nreq = 0; nen = 0; nwe = 0; iowe = 1'b0; addr = 32'h0;
         end
      end
   end

   task automatic op(input logic r_io_r, input logic r_io_w, input logic r_mr,
                     input logic r_mw, input logic [31:0] a, input logic [31:0] wd,
                     input int dly, input logic [31:0] drd, input exp_t e);
      bit done;
      @(posedge clk); #1;
      io_r = r_io_r; io_w = r_io_w; mr = r_mr; mw = r_mw;
      m_iaddr = a; wm_idata = wd; ack_delay = dly; dev_rdata = drd;
      sb.push_back(e);
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(negedge clk);
         if (!stall_o) done = 1'b1;
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL op_timeout: stall_o still %b after 400 cycles, expected 0", stall_o);
      end
      @(posedge clk); #1;
      io_r = 1'b0; io_w = 1'b0; mr = 1'b0; mw = 1'b0;
   endtask

   initial begin
      // Reset state.
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_stall", {31'h0, stall_o}, 32'h0);
      chk("rst_rm", rm_idata, 32'h0);
      chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rst_io_req", {31'h0, io_req}, 32'h0);
      chk("rst_io_err", {31'h0, io_err}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // RAM write/read, including address wrap and ignored byte offset.
      op(0,0,0,1, 32'h0000_0010, 32'hCAFE_F00D, 0, 0, '{32'h0,         2, 1'b0, 0, 1, 1, 1'b0, 32'h4});
      op(0,0,1,0, 32'h0000_0010, 32'h0,         0, 0, '{32'hCAFE_F00D, 3, 1'b0, 0, 1, 0, 1'b0, 32'h4});
      op(0,0,0,1, 32'h0000_1014, 32'h1234_5678, 0, 0, '{32'hCAFE_F00D, 2, 1'b0, 0, 1, 1, 1'b0, 32'h5});
      op(0,0,1,0, 32'h0000_0017, 32'h0,         0, 0, '{32'h1234_5678, 3, 1'b0, 0, 1, 0, 1'b0, 32'h5});
      // IO read acked after 5 cycles; ack exactly on the timeout cycle.
      op(1,0,0,0, 32'hFFFF_F004, 32'h0, 5,   32'h0000_00A5, '{32'h0000_00A5, 6,   1'b0, 5,   0, 0, 1'b0, 32'hFFFF_F004});
      op(1,0,0,0, 32'hFFFF_F008, 32'h0, 255, 32'h5A5A_0001, '{32'h5A5A_0001, 256, 1'b0, 255, 0, 0, 1'b0, 32'hFFFF_F008});
      // IO write never acked: timeout, sticky error, rm_idata unchanged.
      op(0,1,0,0, 32'hFFFF_F00C, 32'h0000_DEAD, 0, 0, '{32'h5A5A_0001, 256, 1'b1, 255, 0, 0, 1'b1, 32'hFFFF_F00C});
      op(0,0,1,0, 32'h0000_0010, 32'h0, 0, 0, '{32'hCAFE_F00D, 3, 1'b1, 0, 1, 0, 1'b0, 32'h4});
      // mr and io_r together: IO wins, RAM untouched.
      op(1,0,1,0, 32'hFFFF_F010, 32'h0, 2, 32'h0000_0077, '{32'h0000_0077, 3, 1'b1, 2, 0, 0, 1'b0, 32'hFFFF_F010});
      // Timed-out IO read returns zero.
      op(1,0,0,0, 32'hFFFF_F014, 32'h0, 0, 32'h0, '{32'h0, 256, 1'b1, 255, 0, 0, 1'b0, 32'hFFFF_F014});

      // Reset while in IO_WAIT.
      @(posedge clk); #1;
      io_r = 1'b1; m_iaddr = 32'hFFFF_F018; ack_delay = 0;
      repeat (3) @(negedge clk);
      chk("wait_io_req", {31'h0, io_req}, 32'h1);
      @(posedge clk); #1;
      rst = 1'b1; io_r = 1'b0;
      @(negedge clk);
      chk("rstcyc_stall", {31'h0, stall_o}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstio_io_req", {31'h0, io_req}, 32'h0);
      chk("rstio_io_err", {31'h0, io_err}, 32'h0);
      chk("rstio_rm", rm_idata, 32'h0);
      chk("rstio_io_addr", io_addr, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Reset while in RAM_ACC of a write: the write must not reach RAM.
      @(posedge clk); #1;
      mw = 1'b1; m_iaddr = 32'h0000_0020; wm_idata = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      rst = 1'b1; mw = 1'b0;
      @(negedge clk);
      chk("rstacc_ram_we", {31'h0, ram_we}, 32'h0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("rstacc_ram_en", {31'h0, ram_en}, 32'h0);
      chk("rstacc_ram_addr", {22'h0, ram_addr}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      op(0,0,1,0, 32'h0000_0020, 32'h0, 0, 0, '{32'h0,         3, 1'b0, 0, 1, 0, 1'b0, 32'h8});
      op(0,0,1,0, 32'h0000_0010, 32'h0, 0, 0, '{32'hCAFE_F00D, 3, 1'b0, 0, 1, 0, 1'b0, 32'h4});

      repeat (3) @(negedge clk);
      if (sb.size() != 0) begin
         checks++; errors++;
         $display("FAIL sb_leftover: %0d entries pending, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mioc_ctrl.md
Name: mioc_ctrl

Overview:
Memory/IO controller that sits directly downstream of the writeback/memory-access stage. It consumes that stage's request strobes (mr, mw, io_r, io_w), word address and store data. It routes each request either to the synchronous data RAM or to the memory-mapped IO bus, stalls the pipeline until the access completes, and returns load data on rm_idata. IO accesses use a req/ack handshake with a timeout guard.

Parameters:
RAM_AW, 10, data RAM word-address width (RAM depth = 2^RAM_AW words)
TIMEOUT, 255, maximum IO wait cycles before forced completion
TO_W, 8, width of the IO timeout counter (must hold TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
mr  in  1  RAM read request (lw to RAM)
mw  in  1  RAM write request (sw to RAM)
io_r  in  1  IO read request
io_w  in  1  IO write request
m_iaddr  in  32  byte address of the access
wm_idata  in  32  store data
rm_idata  out  32  load data returned to the upstream stage
stall_o  out  1  pipeline stall; holds upstream stages while an access is in flight
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  RAM_AW  RAM word address = m_iaddr[RAM_AW+1:2]
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, valid the cycle after ram_en with ram_we=0
io_req  out  1  IO request, held until ack or timeout
io_we  out  1  IO write qualifier
io_addr  out  32  IO byte address
io_wdata  out  32  IO write data
io_rdata  in  32  IO read data, valid when io_ack=1
io_ack  in  1  IO completion, single-cycle pulse
io_err  out  1  sticky IO timeout flag

Behaviour:
- Reset (rst=1 at a rising edge) forces IDLE. All outputs 0: rm_idata, ram_*, io_*, io_err. The rst=1 cycle itself also forces stall_o=0.
- Reset mid-operation: abort at the next edge. io_req drops, no RAM write is issued, the latched request is discarded.
- FSM states: IDLE, RAM_ACC, RAM_CAP, IO_WAIT, DONE.
- IDLE: if any request is high, latch addr, wdata and kind at the edge.
  - If several requests are high, priority is io_r > io_w > mr > mw. The upstream stage guarantees exclusivity; priority only defines the illegal case.
  - Next state: RAM_ACC for mr/mw, IO_WAIT for io_r/io_w.
  - stall_o = 1 combinationally in IDLE when any request is high.
- RAM_ACC: ram_en=1; ram_we=1 for a write. ram_addr and ram_wdata come from the latch. Next state: RAM_CAP for a read, DONE for a write.
- RAM_CAP: capture ram_rdata into rm_idata; go to DONE.
- IO_WAIT: io_req=1, with io_we/io_addr/io_wdata from the latch. The counter increments each cycle.
  - io_ack=1: capture io_rdata into rm_idata (reads only) and go to DONE. An ack in the same cycle the counter reaches TIMEOUT counts as success.
  - Counter reaches TIMEOUT with no ack: rm_idata=0 (reads), io_err set, go to DONE. io_err clears only on rst.
  - io_ack outside IO_WAIT is ignored.
- DONE: stall_o=0, so the pipeline advances at this edge. Always go to IDLE.
- stall_o = 1 in RAM_ACC, RAM_CAP and IO_WAIT.
- rm_idata holds its last value until the next load completes. Writes leave rm_idata unchanged.
- Stall cycles seen by the pipeline:
  - RAM read: 3 (IDLE, RAM_ACC, RAM_CAP).
  - RAM write: 2.
  - IO: 1 + wait cycles up to and including the ack.
- Address handling:
  - m_iaddr[1:0] is ignored (word accesses only).
  - RAM upper address bits are ignored (the RAM image wraps).
  - io_addr is the full 32 bits.

Decomposition:
- Add to shared defines: state encodings (3-bit), MIOC_IO_BASE 32'hFFFF_F000, MIOC_TO_DEFAULT. Reuse RegBus and ZeroWord.
- One natural sub-module: mioc_io_timer (counter + timeout compare, with clear/enable inputs). Everything else stays in mioc_ctrl.

Test Plan:
1. RAM write then read: mw, addr 0x0000_0010, data 0xCAFE_F00D, then mr at the same addr -> ram_we pulse with ram_addr=4; stall_o high 2 then 3 cycles; rm_idata=0xCAFE_F00D in DONE.
2. IO read with ack after 5 wait cycles: io_r, addr 0xFFFF_F004; device returns 0x0000_00A5 -> io_req high 5 cycles with io_we=0; rm_idata=0xA5; io_err=0.
3. IO write with no ack: io_w, TIMEOUT=255 -> io_req held 255 cycles then drops; io_err=1 and stays 1 through further accesses until rst.
4. Ack on the exact TIMEOUT cycle -> treated as success: io_err=0, rm_idata=io_rdata.
5. rst asserted in IO_WAIT and in RAM_ACC (write) -> next edge: io_req=0, no ram_we pulse, state IDLE, all outputs 0.
6. mr and io_r both high -> IO path taken; ram_en never asserted.
